// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus bundle between the milano pipeline and the multi-port register file.
//
// Signals (names follow the register-file port list):
//   ready_o      file -> core   1 = post-reset scrub finished, traffic accepted
//   we_i         core -> file   per-write-port enable
//   waddr_i      core -> file   write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata_i      core -> file   write data, port k at [k*DATA_W +: DATA_W]
//   raddr_i      core -> file   read addresses, port j at [j*ADDR_W +: ADDR_W]
//   rdata_o      file -> core   combinational read data
//   rbusy_o      file -> core   combinational busy bit per read address
//   alloc_i      core -> file   mark alloc_addr_i busy (producer issued)
//   alloc_addr_i core -> file   register to mark busy
//
// Modports:
//   master : the pipeline side (drives addresses, data, enables)
//   slave  : the register file
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                       ready_o;
  logic [NUM_WR-1:0]          we_i;
  logic [NUM_WR*ADDR_W-1:0]   waddr_i;
  logic [NUM_WR*DATA_W-1:0]   wdata_i;
  logic [NUM_RD*ADDR_W-1:0]   raddr_i;
  logic [NUM_RD*DATA_W-1:0]   rdata_o;
  logic [NUM_RD-1:0]          rbusy_o;
  logic                       alloc_i;
  logic [ADDR_W-1:0]          alloc_addr_i;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, alloc_i, alloc_addr_i,
    input  ready_o, rdata_o, rbusy_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, alloc_i, alloc_addr_i,
    output ready_o, rdata_o, rbusy_o
  );
endinterface

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file for the milano core, with
// fixed-priority write ports, optional write-to-read bypass, a per-register
// pending-write (busy) scoreboard and a post-reset scrub that zeroes every
// entry.
//
// Ports:
//   clk_i        in   clock, all state updates on the rising edge
//   rst_i        in   synchronous active-high reset
//   bus          slave side of regfile_mp_if (ready, write ports, read ports,
//                scoreboard allocation)
//   dbg_state_o  out  current controller state (0 = INIT scrub, 1 = RUN)
//
// Handshake: there is no backpressure. ready_o acts as the file-side ready;
// we_i[k] and alloc_i act as per-transfer valids. A write or allocation is
// taken on a rising edge only when its valid is 1 and ready_o is 1 during that
// cycle; valids presented while ready_o is 0 are discarded, not held.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  regfile_mp_if.slave       bus,
  output logic              dbg_state_o
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_scrub_cnt;
  logic [ADDR_W-1:0]   w_scrub_nxt;

  // Storage has no reset: the scrub is what brings it to a known value.
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  // Per write port unpacked views of the flat buses.
  logic [ADDR_W-1:0]   w_waddr  [NUM_WR];
  logic [DATA_W-1:0]   w_wdata  [NUM_WR];
  logic [NUM_WR-1:0]   w_wvalid;
  logic                w_run;
  logic                w_alloc_ok;

  assign w_run = (r_state == ST_RUN);

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign w_waddr[k]  = bus.waddr_i[k*ADDR_W +: ADDR_W];
    assign w_wdata[k]  = bus.wdata_i[k*DATA_W +: DATA_W];
    // A write counts only if it targets a real (non-hardwired) register.
    assign w_wvalid[k] = bus.we_i[k] &&
                         !(ZERO_REG && (w_waddr[k] == '0));
  end

  assign w_alloc_ok = bus.alloc_i && !(ZERO_REG && (bus.alloc_addr_i == '0));

  // ---------------------------------------------------------------------------
  // Controller: INIT walks scrub_cnt over every entry, then RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_INIT;
      r_scrub_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_scrub_cnt <= w_scrub_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scrub_nxt = r_scrub_cnt;
    case (r_state)
      ST_INIT: begin
        w_scrub_nxt = r_scrub_cnt + ADDR_W'(1);
        // The edge that clears the last entry also opens the file.
        if (r_scrub_cnt == ADDR_W'(NUM_REGS - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_scrub_nxt = '0;
      end
    endcase
  end

  assign bus.ready_o = w_run;
  assign dbg_state_o = r_state;

  // ---------------------------------------------------------------------------
  // Data array. Ports are visited in ascending index order so the last
  // non-blocking assignment, i.e. the highest-index port, wins on a clash.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == ST_INIT) begin
        r_regs[r_scrub_cnt] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (w_wvalid[k]) begin
            r_regs[w_waddr[k]] <= w_wdata[k];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. The allocation is applied after the write clears so
  // that a same-cycle alloc + write to one register leaves it busy: the alloc
  // belongs to a newer producer than the write being retired.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else if (w_run) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (w_wvalid[k]) begin
          r_busy[w_waddr[k]] <= 1'b0;
        end
      end
      if (w_alloc_ok) begin
        r_busy[bus.alloc_addr_i] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports (combinational). Bypass loop runs low to high so the highest
  // matching write port ends up driving the forwarded value. Outside RUN the
  // ports are forced to zero so no unscrubbed content ever leaks out.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_rb;

    assign w_ra = bus.raddr_i[j*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = r_regs[w_ra];
      w_rb = r_busy[w_ra];
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.we_i[k] && (w_waddr[k] == w_ra)) begin
            w_rd = w_wdata[k];
            w_rb = 1'b0;
          end
        end
      end
      if (!w_run || (ZERO_REG && (w_ra == '0))) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
    end

    assign bus.rdata_o[j*DATA_W +: DATA_W] = w_rd;
    assign bus.rbusy_o[j]                  = w_rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Two register files (BYPASS=1 and BYPASS=0) driven with identical stimulus
// and checked against a behavioural model of the register array, busy bits
// and scrub sequence.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int RD = 2;
  localparam int WR = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic tb_rst;

  // ---------------- stimulus variables ----------------
  logic [WR-1:0]    tb_we;
  logic [WR*AW-1:0] tb_waddr;
  logic [WR*DW-1:0] tb_wdata;
  logic [RD*AW-1:0] tb_raddr;
  logic             tb_alloc;
  logic [AW-1:0]    tb_alloc_addr;

  regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR)) if_b ();
  regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR)) if_n ();

  assign if_b.we_i = tb_we;         assign if_n.we_i = tb_we;
  assign if_b.waddr_i = tb_waddr;   assign if_n.waddr_i = tb_waddr;
  assign if_b.wdata_i = tb_wdata;   assign if_n.wdata_i = tb_wdata;
  assign if_b.raddr_i = tb_raddr;   assign if_n.raddr_i = tb_raddr;
  assign if_b.alloc_i = tb_alloc;   assign if_n.alloc_i = tb_alloc;
  assign if_b.alloc_addr_i = tb_alloc_addr;
  assign if_n.alloc_addr_i = tb_alloc_addr;

  logic st_b, st_n;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR),
               .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
    .clk_i(clk), .rst_i(tb_rst), .bus(if_b.slave), .dbg_state_o(st_b));

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR),
               .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nob (
    .clk_i(clk), .rst_i(tb_rst), .bus(if_n.slave), .dbg_state_o(st_n));

  // ---------------- reference model ----------------
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            m_run;
  int            m_cnt;

  int total = 0;
  int bad   = 0;

  function automatic int wa(int k);
    return int'(tb_waddr[k*AW +: AW]);
  endfunction

  function automatic int ra(int j);
    return int'(tb_raddr[j*AW +: AW]);
  endfunction

  // Highest-priority write port currently targeting address a, or -1.
  function automatic int winner(int a);
    for (int k = WR - 1; k >= 0; k--)
      if (tb_we[k] && wa(k) == a) return k;
    return -1;
  endfunction

  function automatic logic [DW-1:0] exp_rd(int j, bit byp);
    int a = ra(j);
    int w = winner(a);
    if (!m_run || a == 0) return '0;
    if (byp && w >= 0) return tb_wdata[w*DW +: DW];
    return m_regs[a];
  endfunction

  function automatic logic exp_rb(int j, bit byp);
    int a = ra(j);
    if (!m_run || a == 0) return 1'b0;
    if (byp && winner(a) >= 0) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply one clock edge to the model from the inputs presented this cycle.
  function automatic void model_edge();
    if (tb_rst) begin
      m_run = 0;
      m_cnt = 0;
      for (int i = 0; i < NR; i++) m_busy[i] = 0;
    end else if (!m_run) begin
      m_regs[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NR) m_run = 1;
    end else begin
      for (int a = 1; a < NR; a++) begin
        int w = winner(a);
        if (w >= 0) begin
          m_regs[a] = tb_wdata[w*DW +: DW];
          m_busy[a] = 0;
        end
      end
      if (tb_alloc && tb_alloc_addr != '0) m_busy[tb_alloc_addr] = 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    tb_we = '0; tb_waddr = '0; tb_wdata = '0;
    tb_alloc = 1'b0; tb_alloc_addr = '0;
  endtask

  task automatic set_wr(int k, int a, logic [DW-1:0] d);
    tb_we[k] = 1'b1;
    tb_waddr[k*AW +: AW] = AW'(a);
    tb_wdata[k*DW +: DW] = d;
  endtask

  task automatic set_rd(int j, int a);
    tb_raddr[j*AW +: AW] = AW'(a);
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic cmp(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    #1;
    for (int j = 0; j < RD; j++) begin
      cmp($sformatf("%s byp rdata%0d", tag, j), if_b.rdata_o[j*DW +: DW], exp_rd(j, 1));
      cmp($sformatf("%s byp rbusy%0d", tag, j), DW'(if_b.rbusy_o[j]), DW'(exp_rb(j, 1)));
      cmp($sformatf("%s nob rdata%0d", tag, j), if_n.rdata_o[j*DW +: DW], exp_rd(j, 0));
      cmp($sformatf("%s nob rbusy%0d", tag, j), DW'(if_n.rbusy_o[j]), DW'(exp_rb(j, 0)));
    end
    cmp({tag, " byp ready"}, DW'(if_b.ready_o), DW'(m_run));
    cmp({tag, " nob ready"}, DW'(if_n.ready_o), DW'(m_run));
  endtask

  task automatic rand_inputs();
    tb_we = WR'($urandom);
    for (int k = 0; k < WR; k++) begin
      tb_waddr[k*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1)
                                                            : $urandom_range(0, 7));
      tb_wdata[k*DW +: DW] = $urandom;
    end
    for (int j = 0; j < RD; j++)
      tb_raddr[j*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1)
                                                            : $urandom_range(0, 7));
    tb_alloc = 1'($urandom);
    tb_alloc_addr = AW'($urandom_range(0, 7));
  endtask

  // Scrub with junk traffic: writes/allocs here must leave no trace.
  task automatic scrub(string tag);
    for (int c = 0; c < NR; c++) begin
      rand_inputs();
      check_all(tag);
      tick();
    end
    idle_inputs();
    check_all({tag, " end"});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    tb_raddr = '0;
    tb_rst = 1'b1;
    m_run = 0; m_cnt = 0;
    tick();
    check_all("rst");
    tick();
    tb_rst = 1'b0;
    scrub("scrub1");

    // Post-scrub: a value written now must be wiped by the next reset.
    set_wr(0, 5, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    set_rd(0, 5);
    check_all("r5 written");
    tb_rst = 1'b1;
    tick();
    tb_rst = 1'b0;
    scrub("scrub2");
    set_rd(0, 5);
    check_all("r5 scrubbed");

    // Write priority.
    set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222);
    set_rd(0, 7); set_rd(1, 7);
    check_all("prio same");
    tick();
    idle_inputs();
    check_all("prio after");

    // Hardwired zero register.
    set_wr(0, 0, 32'hFFFF_FFFF);
    tb_alloc = 1'b1; tb_alloc_addr = '0;
    set_rd(0, 0); set_rd(1, 0);
    check_all("zero same");
    tick();
    idle_inputs();
    check_all("zero after");

    // Bypass vs. registered visibility.
    set_wr(0, 3, 32'hA5A5_A5A5);
    set_rd(0, 7); set_rd(1, 3);
    check_all("bypass same");
    tick();
    idle_inputs();
    check_all("bypass next");

    // Scoreboard on r9.
    set_rd(0, 9); set_rd(1, 9);
    tb_alloc = 1'b1; tb_alloc_addr = AW'(9);
    check_all("sb alloc");
    tick();
    idle_inputs();
    check_all("sb busy");
    set_wr(1, 9, 32'h0909_0909);
    tb_alloc = 1'b1; tb_alloc_addr = AW'(9);
    check_all("sb wr+alloc");
    tick();
    idle_inputs();
    check_all("sb still busy");
    set_wr(0, 9, 32'h9999_0000);
    check_all("sb wr clear");
    tick();
    idle_inputs();
    check_all("sb cleared");

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      check_all("rand");
      tick();
    end
    idle_inputs();

    // Reset mid-scrub at scrub_cnt = 10.
    for (int i = 1; i < NR; i++) begin
      tb_alloc = 1'b1; tb_alloc_addr = AW'(i);
      tick();
    end
    idle_inputs();
    tb_rst = 1'b1;
    tick();
    tb_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_all("mid scrub");
      tick();
    end
    tb_rst = 1'b1;
    tick();
    tb_rst = 1'b0;
    scrub("scrub3");
    for (int a = 0; a < NR; a += 2) begin
      set_rd(0, a); set_rd(1, a + 1);
      check_all("busy clear");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the milano core. It is the successor to the 2R/1W register file. It adds configurable width, depth and port counts, multiple write ports with fixed priority, and an optional write-to-read bypass. It also holds a per-register pending-write scoreboard and a post-reset hardware scrub that zeroes every entry. ID reads it, EX/WB write it, and the issue logic reads the busy bits.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of registers (power of two, >= 2); ADDR_W = $clog2(NUM_REGS)
NUM_RD, 2, number of read ports (>= 1)
NUM_WR, 2, number of write ports (>= 1); higher index = higher priority
ZERO_REG, 1, 1: register 0 hardwired to zero, never busy
BYPASS, 1, 1: same-cycle write data and busy-clear forwarded to read ports

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
ready_o  out  1  1 = scrub done, file accepts traffic
we_i  in  NUM_WR  per-port write enable
waddr_i  in  NUM_WR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
wdata_i  in  NUM_WR*DATA_W  write data, port k at [k*DATA_W +: DATA_W]
raddr_i  in  NUM_RD*ADDR_W  read addresses
rdata_o  out  NUM_RD*DATA_W  read data, combinational
rbusy_o  out  NUM_RD  busy bit of each read address, combinational
alloc_i  in  1  mark alloc_addr_i busy (issue of a producer)
alloc_addr_i  in  ADDR_W  register to mark busy

Behaviour:
- State machine has two states: INIT and RUN. A rising edge with rst_i=1 moves to INIT, sets scrub_cnt=0, clears all busy bits and sets ready_o=0.
- INIT, each edge with rst_i=0: regs[scrub_cnt] <= 0 and scrub_cnt++. The edge that zeroes entry NUM_REGS-1 moves to RUN and sets ready_o=1. ready_o is therefore 1 exactly NUM_REGS edges after rst_i deasserts.
- In INIT:
  - we_i and alloc_i are ignored.
  - rdata_o = 0 and rbusy_o = 0 on all ports.
- rst_i asserted mid-scrub or in RUN restarts INIT from entry 0.
- RUN write: for each register a, the winning port is the highest-index k with we_i[k]=1 and waddr=a. regs[a] <= that port's wdata at the edge.
  - Lower-priority same-address writes are dropped.
  - Writes to address 0 are dropped when ZERO_REG=1.
- RUN read, port j (combinational, zero latency):
  - If ZERO_REG and raddr=0: data 0.
  - Else if BYPASS and any we_i[k] matches raddr: data = wdata of the highest-priority matching port.
  - Else: data = regs[raddr].
- Scoreboard: busy[a] is registered, one bit per register, all 0 after reset.
  - Edge with alloc_i=1 in RUN: busy[alloc_addr] <= 1, ignored for addr 0 when ZERO_REG=1.
  - Edge with any valid write to a: busy[a] <= 0.
  - Alloc and write to the same address in the same cycle: alloc wins, busy stays 1 (new producer).
- rbusy_o[j]:
  - 0 if ZERO_REG and raddr=0.
  - Else, if BYPASS and a write to raddr is present this cycle: 0, consistent with the forwarded data. A same-cycle alloc does not affect rbusy_o until the next edge.
  - Else: busy[raddr].
- With BYPASS=0, reads and busy return pre-edge stored state only. New write data is visible in the cycle after the edge.
- Registers need no data reset beyond the scrub. Busy bits and the FSM use rst_i.
- No X may appear on rdata_o after ready_o=1.

Test Plan:
- Scrub: NUM_REGS=32. Preload entry 5 with 0xDEAD_BEEF via a backdoor force, assert rst_i for 1 cycle → ready_o=0 for 32 cycles, 1 on the 32nd edge; then a read of r5 returns 0. Writes issued during INIT are not stored.
- Priority: RUN, we_i=2'b11, both ports addr 7, data 0x1111 / 0x2222 → bypass read of r7 returns 0x2222 in the same cycle; after the edge, r7 = 0x2222.
- Zero reg: write 0xFFFF_FFFF to r0 on port 0 and alloc r0 → r0 reads 0 and rbusy=0, now and after the edge.
- Bypass: write 0xA5A5_A5A5 to r3 while port 1 reads r3 (old value 0) → rdata port 1 = 0xA5A5_A5A5 in the same cycle. Repeat with BYPASS=0 → 0 in that cycle, 0xA5A5_A5A5 in the next.
- Scoreboard:
  - Alloc r9 → rbusy=1 from the next cycle.
  - Write r9 with alloc r9 in the same cycle → rbusy stays 1.
  - A later write r9 with no alloc → rbusy=0 in that same cycle (bypass) and busy cleared after the edge.
- Reset mid-scrub: assert rst_i at scrub_cnt=10 → the scrub restarts; ready_o rises 32 edges after the second deassertion, and all busy bits read 0.
